// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: direction/output latches, synchronised inputs, edge interrupts.
// Define GPIO_DEBOUNCE_EN to insert a per-pin debounce filter between the synchroniser and edge detect.
module gpio_port #(
    parameter int WIDTH           = 32,
    parameter int N_GPIO          = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  addr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              we,
    output logic [WIDTH-1:0]  rdata,
    input  logic [N_GPIO-1:0] gpio_in,
    output logic [N_GPIO-1:0] gpio_out,
    output logic [N_GPIO-1:0] gpio_oe,
    output logic              irq
);

    localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_DATA_IN  = 3'd2;
    localparam logic [2:0] ADDR_IRQ_EN   = 3'd3;
    localparam logic [2:0] ADDR_IRQ_PEND = 3'd4;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd5;

`ifdef GPIO_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    // The filter delays the first visible level by DEBOUNCE_CYCLES, so arming is stretched to match.
    localparam int ARM_EDGES = 3 + (DB_EN ? DEBOUNCE_CYCLES : 0);
    localparam int ARM_W     = $clog2(ARM_EDGES + 1);

    logic [N_GPIO-1:0] data_out;
    logic [N_GPIO-1:0] dir;
    logic [N_GPIO-1:0] irq_en;
    logic [N_GPIO-1:0] irq_pend;
    logic [N_GPIO-1:0] edge_sel;
    logic [N_GPIO-1:0] s1;
    logic [N_GPIO-1:0] s2;
    logic [N_GPIO-1:0] s3;
    logic [N_GPIO-1:0] pin_val;
    logic [ARM_W-1:0]  arm_cnt;

    logic [2:0]        sel;
    logic [N_GPIO-1:0] wr_data;
    logic              armed;
    logic [N_GPIO-1:0] rise;
    logic [N_GPIO-1:0] fall;
    logic [N_GPIO-1:0] ev;
    logic [N_GPIO-1:0] pend_clr;
    logic              unused_bits;

    assign sel         = addr[2:0];
    assign wr_data     = wdata[N_GPIO-1:0];
    assign unused_bits = ^{addr, wdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= gpio_in;
            s2 <= s1;
            s3 <= pin_val;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [N_GPIO-1:0] db;
    logic [DB_W-1:0]   db_cnt [N_GPIO];

    // A pin's filtered level only follows s2 once it has disagreed for DEBOUNCE_CYCLES edges in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db <= '0;
            for (int i = 0; i < N_GPIO; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_GPIO; i++) begin
                if (s2[i] != db[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        db[i]     <= s2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign pin_val = db;
`else
    assign pin_val = s2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + ARM_W'(1);
        end
    end

    // Events are masked until the synchroniser has flushed its reset zeros.
    assign armed    = (arm_cnt == ARM_W'(ARM_EDGES));
    assign rise     = pin_val & ~s3;
    assign fall     = ~pin_val & s3;
    assign ev       = armed ? ((edge_sel & rise) | (~edge_sel & fall)) : '0;
    assign pend_clr = (we && sel == ADDR_IRQ_PEND) ? wr_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            dir      <= '0;
            irq_en   <= '0;
            edge_sel <= '0;
            irq_pend <= '0;
        end else begin
            if (we) begin
                case (sel)
                    ADDR_DATA_OUT: data_out <= wr_data;
                    ADDR_DIR:      dir      <= wr_data;
                    ADDR_IRQ_EN:   irq_en   <= wr_data;
                    ADDR_EDGE_SEL: edge_sel <= wr_data;
                    default: ;
                endcase
            end
            // A new event outranks a same-cycle write-1-to-clear.
            irq_pend <= (irq_pend & ~pend_clr) | ev;
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            ADDR_DATA_OUT: rdata[N_GPIO-1:0] = data_out;
            ADDR_DIR:      rdata[N_GPIO-1:0] = dir;
            ADDR_DATA_IN:  rdata[N_GPIO-1:0] = pin_val;
            ADDR_IRQ_EN:   rdata[N_GPIO-1:0] = irq_en;
            ADDR_IRQ_PEND: rdata[N_GPIO-1:0] = irq_pend;
            ADDR_EDGE_SEL: rdata[N_GPIO-1:0] = edge_sel;
            default:       rdata = '0;
        endcase
    end

    assign gpio_out = data_out;
    assign gpio_oe  = dir;
    assign irq      = |(irq_pend & irq_en);

endmodule
